// File: rtl/bomb_pkg.sv
// Shared types, constants and helpers for the bomb map logic.
package bomb_pkg;

  localparam int unsigned CELLS   = 100;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] CELL_EMPTY   = 2'd0;
  localparam logic [1:0] CELL_ONE     = 2'd1;
  localparam logic [1:0] CELL_EXPLODE = 2'd3;

  localparam int unsigned FIELD_MIN = 1;
  localparam int unsigned FIELD_MAX = 8;

  localparam logic [1:0] GS_PLAYING = 2'd0;
  localparam logic [1:0] GS_B_WINS  = 2'd1;
  localparam logic [1:0] GS_A_WINS  = 2'd2;
  localparam logic [1:0] GS_DRAW    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Cell index 10*x+y; only meaningful for in-field coordinates.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    logic [7:0] sum;
    sum = 8'(x) * 8'd10 + 8'(y);
    return IDX_W'(sum);
  endfunction

  function automatic logic [CELLS-1:0] field_mask(input int unsigned lo,
                                                  input int unsigned hi);
    logic [CELLS-1:0] m;
    m = '0;
    for (int unsigned x = 0; x < 10; x++) begin
      for (int unsigned y = 0; y < 10; y++) begin
        if (x >= lo && x <= hi && y >= lo && y <= hi) m[x*10+y] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [CELLS-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < CELLS; i++) c = c + 7'(v[i]);
    return CNT_W'(c);
  endfunction

endpackage

// File: rtl/bomb_rr_arb.sv
// Two-requester round-robin arbiter; pointer only advances on a contested grant.
module bomb_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_valid_c,
  output logic gnt_b_c
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d       = ptr_q;
    gnt_valid_c = en & (req_a | req_b);
    gnt_b_c     = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_b_c = ptr_q;
        ptr_d   = ~ptr_q;
      end else begin
        gnt_b_c = req_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bomb_placer.sv
// Authoritative 10x10 bomb map: merges step results and arbitrated player drops.
module bomb_placer
  import bomb_pkg::*;
#(
  parameter int unsigned MAX_BOMBS = 2,
  parameter int unsigned FIELD_MIN = bomb_pkg::FIELD_MIN,
  parameter int unsigned FIELD_MAX = bomb_pkg::FIELD_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         game_state,
  input  logic               step_tick,
  input  logic [CELLS-1:0]   i_stepMap_0,
  input  logic [CELLS-1:0]   i_stepMap_1,
  input  logic               reqA,
  input  logic               reqB,
  input  logic [COORD_W-1:0] playerAx,
  input  logic [COORD_W-1:0] playerAy,
  input  logic [COORD_W-1:0] playerBx,
  input  logic [COORD_W-1:0] playerBy,
  output logic [CELLS-1:0]   o_curBombMap_0,
  output logic [CELLS-1:0]   o_curBombMap_1,
  output logic               ackA,
  output logic               ackB,
  output logic               nackA,
  output logic               nackB,
  output logic [CNT_W-1:0]   activeA,
  output logic [CNT_W-1:0]   activeB
);

  localparam logic [CELLS-1:0] FMASK = field_mask(FIELD_MIN, FIELD_MAX);

  state_e               state_q, state_d;
  logic [CELLS-1:0]     map0_q, map0_d, map1_q, map1_d;
  logic [CELLS-1:0]     own_a_q, own_a_d, own_b_q, own_b_d;
  logic                 gnt_b_q, gnt_b_d;
  logic [COORD_W-1:0]   gx_q, gx_d, gy_q, gy_d;
  logic                 reject_q, reject_d;
  logic                 ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic                 nack_a_q, nack_a_d, nack_b_q, nack_b_d;

  logic                 arb_en_c, gnt_valid_c, gnt_b_c;
  logic [CELLS-1:0]     mrg0_c, mrg1_c, explode_c;
  logic                 in_bounds_c, at_limit_c;
  logic [IDX_W-1:0]     idx_c;
  logic [1:0]           tgt_val_c;

  assign arb_en_c = (state_q == ST_IDLE) && !(ack_a_q | ack_b_q | nack_a_q | nack_b_q);

  bomb_rr_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (arb_en_c),
    .req_a       (reqA),
    .req_b       (reqB),
    .gnt_valid_c (gnt_valid_c),
    .gnt_b_c     (gnt_b_c)
  );

  // Post-merge view of the map and the target cell of the current grant.
  always_comb begin
    mrg0_c      = step_tick ? (i_stepMap_0 & FMASK) : map0_q;
    mrg1_c      = step_tick ? (i_stepMap_1 & FMASK) : map1_q;
    explode_c   = map0_q & map1_q;
    in_bounds_c = (32'(gx_q) >= FIELD_MIN) && (32'(gx_q) <= FIELD_MAX) &&
                  (32'(gy_q) >= FIELD_MIN) && (32'(gy_q) <= FIELD_MAX);
    idx_c       = in_bounds_c ? cell_idx(gx_q, gy_q) : '0;
    tgt_val_c   = {mrg1_c[idx_c], mrg0_c[idx_c]};
    at_limit_c  = 32'(gnt_b_q ? popcount(own_b_q) : popcount(own_a_q)) >= MAX_BOMBS;
  end

  always_comb begin
    state_d  = state_q;
    gnt_b_d  = gnt_b_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    reject_d = reject_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    nack_a_d = 1'b0;
    nack_b_d = 1'b0;
    map0_d   = mrg0_c;
    map1_d   = mrg1_c;
    own_a_d  = step_tick ? (own_a_q & ~explode_c) : own_a_q;
    own_b_d  = step_tick ? (own_b_q & ~explode_c) : own_b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          state_d = ST_CHECK;
          gnt_b_d = gnt_b_c;
          gx_d    = gnt_b_c ? playerBx : playerAx;
          gy_d    = gnt_b_c ? playerBy : playerAy;
        end
      end
      ST_CHECK: begin
        reject_d = (game_state != GS_PLAYING) || !in_bounds_c ||
                   (tgt_val_c != CELL_EMPTY) || at_limit_c;
        state_d  = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        // A step landing now may have filled the cell; re-check against it.
        if (!reject_q && (game_state == GS_PLAYING) && (tgt_val_c == CELL_EMPTY)) begin
          map0_d[idx_c] = CELL_ONE[0];
          map1_d[idx_c] = CELL_ONE[1];
          if (gnt_b_q) own_b_d[idx_c] = 1'b1;
          else         own_a_d[idx_c] = 1'b1;
          ack_a_d = !gnt_b_q;
          ack_b_d = gnt_b_q;
        end else begin
          nack_a_d = !gnt_b_q;
          nack_b_d = gnt_b_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      map0_q   <= '0;
      map1_q   <= '0;
      own_a_q  <= '0;
      own_b_q  <= '0;
      gnt_b_q  <= 1'b0;
      gx_q     <= '0;
      gy_q     <= '0;
      reject_q <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      nack_a_q <= 1'b0;
      nack_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      map0_q   <= map0_d;
      map1_q   <= map1_d;
      own_a_q  <= own_a_d;
      own_b_q  <= own_b_d;
      gnt_b_q  <= gnt_b_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      reject_q <= reject_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      nack_a_q <= nack_a_d;
      nack_b_q <= nack_b_d;
    end
  end

  assign o_curBombMap_0 = map0_q;
  assign o_curBombMap_1 = map1_q;
  assign ackA           = ack_a_q;
  assign ackB           = ack_b_q;
  assign nackA          = nack_a_q;
  assign nackB          = nack_b_q;
  assign activeA        = popcount(own_a_q);
  assign activeB        = popcount(own_b_q);

endmodule

// File: tb/tb_bomb_placer.sv
// Self-checking bench for bomb_placer: vector table, corner sequences, random vs model.
module tb_bomb_placer;
  import bomb_pkg::*;

  localparam int unsigned MAXB = 2;
  localparam int FMIN = 1;
  localparam int FMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  game_state;
  logic        step_tick;
  logic [99:0] i_stepMap_0, i_stepMap_1;
  logic        reqA, reqB;
  logic [3:0]  playerAx, playerAy, playerBx, playerBy;
  logic [99:0] o_curBombMap_0, o_curBombMap_1;
  logic        ackA, ackB, nackA, nackB;
  logic [3:0]  activeA, activeB;

  always #5 clk = ~clk;

  bomb_placer #(.MAX_BOMBS(MAXB), .FIELD_MIN(FMIN), .FIELD_MAX(FMAX)) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .step_tick(step_tick),
    .i_stepMap_0(i_stepMap_0), .i_stepMap_1(i_stepMap_1),
    .reqA(reqA), .reqB(reqB),
    .playerAx(playerAx), .playerAy(playerAy), .playerBx(playerBx), .playerBy(playerBy),
    .o_curBombMap_0(o_curBombMap_0), .o_curBombMap_1(o_curBombMap_1),
    .ackA(ackA), .ackB(ackB), .nackA(nackA), .nackB(nackB),
    .activeA(activeA), .activeB(activeB)
  );

  typedef struct {
    bit         pb;
    int         x;
    int         y;
    logic [1:0] gs;
    logic [3:0] exp_p;
    int         exp_a;
    int         exp_b;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int mc[100];
  bit ma[100];
  bit mb[100];
  int step_vals[100];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit in_field(input int i);
    int x = i / 10;
    int y = i % 10;
    return (x >= FMIN && x <= FMAX && y >= FMIN && y <= FMAX);
  endfunction

  function automatic int own_cnt(input bit b);
    int c = 0;
    for (int i = 0; i < 100; i++) c += b ? int'(mb[i]) : int'(ma[i]);
    return c;
  endfunction

  function automatic logic [99:0] plane(input int b);
    logic [99:0] v;
    for (int i = 0; i < 100; i++) v[i] = 1'((mc[i] >> b) & 1);
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 100; i++) begin
      mc[i] = 0; ma[i] = 0; mb[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 100; i++) begin
      if (mc[i] == 3) begin ma[i] = 0; mb[i] = 0; end
      mc[i] = in_field(i) ? step_vals[i] : 0;
    end
  endfunction

  function automatic bit model_req(input bit pb, input int x, input int y, input logic [1:0] gs);
    int i;
    if (gs != 2'd0) return 0;
    if (x < FMIN || x > FMAX || y < FMIN || y > FMAX) return 0;
    i = 10 * x + y;
    if (mc[i] != 0) return 0;
    if (own_cnt(pb) >= int'(MAXB)) return 0;
    mc[i] = 1;
    if (pb) mb[i] = 1; else ma[i] = 1;
    return 1;
  endfunction

  function automatic logic [3:0] exp_pulse(input bit pb, input bit ok);
    if (!pb) return ok ? 4'b1000 : 4'b0100;
    return ok ? 4'b0010 : 4'b0001;
  endfunction

  function automatic logic [3:0] pulses();
    return {ackA, nackA, ackB, nackB};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_map0"}, o_curBombMap_0, plane(0));
    chk({tag, "_map1"}, o_curBombMap_1, plane(1));
    chk({tag, "_actA"}, activeA, 4'(own_cnt(0)));
    chk({tag, "_actB"}, activeB, 4'(own_cnt(1)));
  endtask

  task automatic do_reset();
    rst = 1; reqA = 0; reqB = 0; step_tick = 0; game_state = 0;
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic wait_pulse(output logic [3:0] p, output int cyc);
    p = '0; cyc = 0;
    while (p == 4'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      p = pulses();
    end
  endtask

  task automatic set_player(input bit pb, input int x, input int y);
    if (pb) begin reqB = 1; playerBx = 4'(x); playerBy = 4'(y); end
    else    begin reqA = 1; playerAx = 4'(x); playerAy = 4'(y); end
  endtask

  task automatic do_req(input bit pb, input int x, input int y, input logic [1:0] gs,
                        output logic [3:0] p, output int cyc);
    game_state = gs;
    set_player(pb, x, y);
    wait_pulse(p, cyc);
    reqA = 0; reqB = 0; game_state = 0;
    @(negedge clk);
    chk("pulse_one_clk", pulses(), 4'b0);
  endtask

  task automatic drive_step();
    for (int i = 0; i < 100; i++) begin
      i_stepMap_0[i] = 1'(step_vals[i] & 1);
      i_stepMap_1[i] = 1'((step_vals[i] >> 1) & 1);
    end
  endtask

  task automatic clear_step_vals();
    for (int i = 0; i < 100; i++) step_vals[i] = 0;
  endtask

  task automatic apply_step();
    drive_step();
    step_tick = 1;
    @(negedge clk);
    step_tick = 0;
    model_step();
  endtask

  task automatic do_pair(input int ax, input int ay, input int bx, input int by, input bit b_first);
    logic [3:0] p;
    int cyc;
    set_player(0, ax, ay);
    set_player(1, bx, by);
    wait_pulse(p, cyc);
    chk("pair_first", p, b_first ? 4'b0010 : 4'b1000);
    chk("pair_first_lat", cyc, 3);
    if (b_first) reqB = 0; else reqA = 0;
    wait_pulse(p, cyc);
    chk("pair_second", p, b_first ? 4'b1000 : 4'b0010);
    chk("pair_second_lat", cyc, 4);
    reqA = 0; reqB = 0;
    @(negedge clk);
    if (b_first) begin void'(model_req(1, bx, by, 0)); void'(model_req(0, ax, ay, 0)); end
    else         begin void'(model_req(0, ax, ay, 0)); void'(model_req(1, bx, by, 0)); end
    check_state("pair");
  endtask

  // Request from A whose COMMIT cycle coincides with a step tick.
  task automatic collide(input int x, input int y, output logic [3:0] p);
    set_player(0, x, y);
    @(negedge clk);
    @(negedge clk);
    drive_step();
    step_tick = 1;
    @(negedge clk);
    step_tick = 0;
    p = pulses();
    reqA = 0;
    @(negedge clk);
  endtask

  vec_t tbl[11];

  initial begin
    logic [3:0] p;
    logic [3:0] acc;
    int cyc;
    bit ok;

    tbl[0]  = '{pb:0, x:1, y:1, gs:2'd0, exp_p:4'b1000, exp_a:1, exp_b:0};
    tbl[1]  = '{pb:0, x:1, y:2, gs:2'd0, exp_p:4'b1000, exp_a:2, exp_b:0};
    tbl[2]  = '{pb:0, x:1, y:3, gs:2'd0, exp_p:4'b0100, exp_a:2, exp_b:0};
    tbl[3]  = '{pb:1, x:1, y:1, gs:2'd0, exp_p:4'b0001, exp_a:2, exp_b:0};
    tbl[4]  = '{pb:1, x:0, y:5, gs:2'd0, exp_p:4'b0001, exp_a:2, exp_b:0};
    tbl[5]  = '{pb:1, x:9, y:1, gs:2'd0, exp_p:4'b0001, exp_a:2, exp_b:0};
    tbl[6]  = '{pb:1, x:5, y:6, gs:2'd2, exp_p:4'b0001, exp_a:2, exp_b:0};
    tbl[7]  = '{pb:1, x:8, y:8, gs:2'd0, exp_p:4'b0010, exp_a:2, exp_b:1};
    tbl[8]  = '{pb:1, x:5, y:6, gs:2'd3, exp_p:4'b0001, exp_a:2, exp_b:1};
    tbl[9]  = '{pb:1, x:1, y:8, gs:2'd0, exp_p:4'b0010, exp_a:2, exp_b:2};
    tbl[10] = '{pb:1, x:4, y:4, gs:2'd0, exp_p:4'b0001, exp_a:2, exp_b:2};

    rst = 1; game_state = 0; step_tick = 0; reqA = 0; reqB = 0;
    i_stepMap_0 = '0; i_stepMap_1 = '0;
    playerAx = 0; playerAy = 0; playerBx = 0; playerBy = 0;
    clear_step_vals();
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
    check_state("reset");
    chk("reset_pulses", pulses(), 4'b0);

    // Basic placement by A, B idle.
    do_req(0, 3, 4, 2'd0, p, cyc);
    chk("basic_pulse", p, 4'b1000);
    chk("basic_lat", cyc, 3);
    chk("basic_cell34", {o_curBombMap_1[34], o_curBombMap_0[34]}, 2'd1);
    chk("basic_actA", activeA, 4'd1);
    chk("basic_actB", activeB, 4'd0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      void'(model_req(tbl[i].pb, tbl[i].x, tbl[i].y, tbl[i].gs));
      do_req(tbl[i].pb, tbl[i].x, tbl[i].y, tbl[i].gs, p, cyc);
      chk($sformatf("tbl%0d_pulse", i), p, tbl[i].exp_p);
      chk($sformatf("tbl%0d_lat", i), cyc, 3);
      chk($sformatf("tbl%0d_actA", i), activeA, 4'(tbl[i].exp_a));
      chk($sformatf("tbl%0d_actB", i), activeB, 4'(tbl[i].exp_b));
      check_state("tbl");
    end

    // Simultaneous requests alternate winners.
    do_reset();
    do_pair(2, 2, 5, 5, 0);
    do_pair(3, 3, 6, 6, 1);

    // Two exploding A bombs released in a single step.
    do_reset();
    do_req(0, 3, 4, 2'd0, p, cyc);
    do_req(0, 5, 6, 2'd0, p, cyc);
    void'(model_req(0, 3, 4, 0));
    void'(model_req(0, 5, 6, 0));
    clear_step_vals();
    step_vals[34] = 3; step_vals[56] = 3;
    apply_step();
    chk("merge_pre_actA", activeA, 4'd2);
    chk("merge_cell56", {o_curBombMap_1[56], o_curBombMap_0[56]}, 2'd3);
    clear_step_vals();
    apply_step();
    chk("merge_post_actA", activeA, 4'd0);
    check_state("merge");

    // Placement committing on a step tick.
    do_reset();
    clear_step_vals();
    step_vals[77] = 2; step_vals[23] = 1;
    apply_step();
    clear_step_vals();
    step_vals[77] = 3; step_vals[23] = 2;
    collide(4, 4, p);
    chk("collide_ack", p, 4'b1000);
    model_step();
    mc[44] = 1; ma[44] = 1;
    chk("collide_cell44", {o_curBombMap_1[44], o_curBombMap_0[44]}, 2'd1);
    check_state("collide");
    clear_step_vals();
    step_vals[44] = 2; step_vals[23] = 3; step_vals[45] = 1;
    collide(4, 5, p);
    chk("collide_nack", p, 4'b0100);
    model_step();
    chk("collide_cell45", {o_curBombMap_1[45], o_curBombMap_0[45]}, 2'd1);
    check_state("collide2");

    // Game over raised while in CHECK.
    set_player(0, 6, 6);
    @(negedge clk);
    game_state = 2'd2;
    wait_pulse(p, cyc);
    chk("gs_abort_pulse", p, 4'b0100);
    game_state = 0; reqA = 0;
    @(negedge clk);
    check_state("gs_abort");

    // Reset in CHECK discards the transaction.
    set_player(0, 7, 7);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    acc = pulses();
    rst = 0; reqA = 0;
    repeat (6) begin
      @(negedge clk);
      acc = acc | pulses();
    end
    chk("rst_abort_pulse", acc, 4'b0);
    model_clear();
    check_state("rst_abort");

    // Randomized requests and natural countdown steps against the model.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        for (int i = 0; i < 100; i++)
          step_vals[i] = (mc[i] == 0 || mc[i] == 3) ? 0 : mc[i] + 1;
        if ($urandom_range(0, 3) == 0)
          step_vals[$urandom_range(0, 99)] = int'($urandom_range(0, 3));
        apply_step();
        check_state("rnd_step");
      end else begin
        bit         pb;
        int         x, y;
        logic [1:0] gs;
        pb = 1'($urandom_range(0, 1));
        x  = int'($urandom_range(0, 9));
        y  = int'($urandom_range(0, 9));
        gs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        ok = model_req(pb, x, y, gs);
        do_req(pb, x, y, gs, p, cyc);
        chk("rnd_pulse", p, exp_pulse(pb, ok));
        chk("rnd_lat", cyc, 3);
        check_state("rnd_req");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
